tdm_demux_1x7: RTL and testbench

TDM_DEMUX_1X7 -- requirements
Module: tdm_demux_1x7

---
 rtl/tdm_demux_1x7_pkg.sv | 19 +
 rtl/slot_counter_mod7.sv | 38 +++
 rtl/tdm_demux_1x7.sv | 107 ++++++++++
 tb/tb_tdm_demux_1x7.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux_1x7_pkg.sv
// Shared constants and types for the 1-to-7 TDM demultiplexer.
// Holds the slot geometry and the HUNT/RUN state encoding.
package tdm_demux_1x7_pkg;

    localparam int unsigned NumSlots = 7;
    localparam int unsigned SlotW    = 3;
    localparam int unsigned ShadowW  = NumSlots - 1;

    typedef logic [SlotW-1:0] slot_t;

    localparam slot_t FirstSlot = slot_t'(0);
    localparam slot_t LastSlot  = slot_t'(NumSlots - 1);

    typedef enum logic {
        StHunt = 1'b0,
        StRun  = 1'b1
    } state_e;

endpackage

// File: rtl/slot_counter_mod7.sv
// Modulo-7 slot index counter with clear, load-to-1 and wrapping increment.
// Priority: clear, then load-1, then increment.
module slot_counter_mod7
    import tdm_demux_1x7_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  clr_i,
    input  logic  load1_i,
    input  logic  inc_i,
    output slot_t cnt_o
);

    slot_t cnt_q;
    slot_t cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = FirstSlot;
        end else if (load1_i) begin
            cnt_d = slot_t'(1);
        end else if (inc_i) begin
            cnt_d = (cnt_q == LastSlot) ? FirstSlot : cnt_q + slot_t'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= FirstSlot;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/tdm_demux_1x7.sv
// Serial 7-slot TDM demultiplexer: aligns on sync, collects slots into a shadow
// register and publishes each complete frame on o with a one-cycle valid pulse.
module tdm_demux_1x7
    import tdm_demux_1x7_pkg::*;
#(
    parameter bit STRICT_SYNC = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                din,
    input  logic                sync,
    input  logic                en,
    output logic [NumSlots-1:0] o,
    output slot_t               s,
    output logic                valid,
    output logic                sync_err
);

    state_e               state_q, state_d;
    logic [ShadowW-1:0]   shadow_q, shadow_d;
    logic [NumSlots-1:0]  o_q, o_d;
    logic                 valid_q, valid_d;
    logic                 sync_err_q, sync_err_d;

    slot_t slot;
    logic  cnt_clr;
    logic  cnt_load1;
    logic  cnt_inc;

    slot_counter_mod7 u_slot_counter (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clr_i   (cnt_clr),
        .load1_i (cnt_load1),
        .inc_i   (cnt_inc),
        .cnt_o   (slot)
    );

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        o_d        = o_q;
        valid_d    = 1'b0;
        sync_err_d = 1'b0;
        cnt_clr    = 1'b0;
        cnt_load1  = 1'b0;
        cnt_inc    = 1'b0;

        if (en) begin
            unique case (state_q)
                StHunt: begin
                    if (sync) begin
                        shadow_d[0] = din;
                        cnt_load1   = 1'b1;
                        state_d     = StRun;
                    end
                end
                StRun: begin
                    if (sync && (slot != FirstSlot)) begin
                        // Misplaced sync: drop the partial frame and restart on this bit.
                        sync_err_d  = 1'b1;
                        shadow_d[0] = din;
                        cnt_load1   = 1'b1;
                    end else if (STRICT_SYNC && !sync && (slot == FirstSlot)) begin
                        sync_err_d = 1'b1;
                        cnt_clr    = 1'b1;
                        state_d    = StHunt;
                    end else if (slot == LastSlot) begin
                        // Slot 6 goes straight to the output; it never needs shadow storage.
                        o_d     = {din, shadow_q};
                        valid_d = 1'b1;
                        cnt_inc = 1'b1;
                    end else begin
                        shadow_d[slot] = din;
                        cnt_inc        = 1'b1;
                    end
                end
                default: begin
                    state_d = StHunt;
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StHunt;
            shadow_q   <= '0;
            o_q        <= '0;
            valid_q    <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            o_q        <= o_d;
            valid_q    <= valid_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign o        = o_q;
    assign s        = slot;
    assign valid    = valid_q;
    assign sync_err = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_1x7.sv
// Self-checking bench for tdm_demux_1x7: scoreboarded frames plus per-scenario inline checks.
module tb_tdm_demux_1x7;

    logic       clk;
    logic       rst_n;
    logic       din;
    logic       sync;
    logic       en;
    logic [6:0] o;
    logic [2:0] s;
    logic       valid;
    logic       sync_err;
    logic [6:0] o_st;
    logic [2:0] s_st;
    logic       valid_st;
    logic       sync_err_st;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [6:0] sb[$];
    int         vcyc[$];

    tdm_demux_1x7 #(.STRICT_SYNC(1'b0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .sync     (sync),
        .en       (en),
        .o        (o),
        .s        (s),
        .valid    (valid),
        .sync_err (sync_err)
    );

    tdm_demux_1x7 #(.STRICT_SYNC(1'b1)) dut_st (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .sync     (sync),
        .en       (en),
        .o        (o_st),
        .s        (s_st),
        .valid    (valid_st),
        .sync_err (sync_err_st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor for the non-strict instance.
    always @(negedge clk) begin
        if (valid) begin
            logic [6:0] exp_o;
            checks++;
            vcyc.push_back(cyc);
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_valid o=%b (no frame expected)", o);
            end else begin
                exp_o = sb.pop_front();
                if (o !== exp_o) begin
                    failures++;
                    $display("FAIL sb_frame o=%b expected=%b", o, exp_o);
                end
            end
        end
        if (valid || sync_err) begin
            checks++;
            if (valid && sync_err) begin
                failures++;
                $display("FAIL valid_and_sync_err valid=%b sync_err=%b expected not both", valid,
                         sync_err);
            end
        end
    end

    task automatic drive(input logic e, input logic d, input logic sy);
        en   = e;
        din  = d;
        sync = sy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b1);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
    endtask

    // Sends one sync-led frame; optional idle (en=0) cycles with random din/sync between bits.
    task automatic send_frame(input logic [6:0] bits, input bit toggle);
        for (int k = 0; k < 7; k++) begin
            if (toggle) drive(1'b0, 1'($urandom), 1'($urandom));
            if (k == 6) sb.push_back(bits);
            drive(1'b1, bits[k], (k == 0));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b1);
        checks++;
        if (o !== 7'b0) begin failures++; $display("FAIL reset_o o=%b expected=0000000", o); end
        checks++;
        if (s !== 3'd0) begin failures++; $display("FAIL reset_s s=%0d expected=0", s); end
        checks++;
        if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid valid=%b expected=0", valid); end
        checks++;
        if (sync_err !== 1'b0) begin
            failures++; $display("FAIL reset_sync_err sync_err=%b expected=0", sync_err);
        end
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b0);
        checks++;
        if (s !== 3'd0) begin failures++; $display("FAIL hunt_ignore_s s=%0d expected=0", s); end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_basic_frame();
        logic [6:0] bits;
        bits = 7'b1001101;
        do_reset();
        for (int k = 0; k < 7; k++) begin
            if (k == 6) sb.push_back(bits);
            drive(1'b1, bits[k], (k == 0));
            checks++;
            if (s !== 3'((k + 1) % 7)) begin
                failures++; $display("FAIL basic_s slot=%0d s=%0d expected=%0d", k, s, (k + 1) % 7);
            end
        end
        checks++;
        if (valid !== 1'b1 || o !== 7'b1001101) begin
            failures++; $display("FAIL basic_out valid=%b o=%b expected valid=1 o=1001101", valid, o);
        end
        drive(1'b0, 1'b1, 1'b1);
        checks++;
        if (valid !== 1'b0 || o !== 7'b1001101) begin
            failures++; $display("FAIL basic_hold valid=%b o=%b expected valid=0 o=1001101", valid, o);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        vcyc.delete();
        send_frame(7'b0110011, 1'b0);
        send_frame(7'b1011100, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (vcyc.size() != 2) begin
            failures++; $display("FAIL b2b_count pulses=%0d expected=2", vcyc.size());
        end else begin
            checks++;
            if (vcyc[1] - vcyc[0] != 7) begin
                failures++; $display("FAIL b2b_spacing gap=%0d expected=7", vcyc[1] - vcyc[0]);
            end
        end
        checks++;
        if (o !== 7'b1011100) begin failures++; $display("FAIL b2b_last_o o=%b expected=1011100", o); end
    endtask

    task automatic test_en_toggle();
        do_reset();
        send_frame(7'b1001101, 1'b1);
        checks++;
        if (valid !== 1'b1 || o !== 7'b1001101) begin
            failures++; $display("FAIL toggle_out valid=%b o=%b expected valid=1 o=1001101", valid, o);
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_sync_err();
        logic [6:0] nf;
        nf = 7'b0101100;
        do_reset();
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b1, (k == 0));
        checks++;
        if (s !== 3'd4) begin failures++; $display("FAIL serr_pre_s s=%0d expected=4", s); end
        drive(1'b1, nf[0], 1'b1);
        checks++;
        if (sync_err !== 1'b1 || valid !== 1'b0 || s !== 3'd1) begin
            failures++;
            $display("FAIL serr_pulse sync_err=%b valid=%b s=%0d expected 1 0 1", sync_err, valid, s);
        end
        for (int k = 1; k < 7; k++) begin
            if (k == 6) sb.push_back(nf);
            drive(1'b1, nf[k], 1'b0);
        end
        checks++;
        if (valid !== 1'b1 || sync_err !== 1'b0) begin
            failures++; $display("FAIL serr_recover valid=%b sync_err=%b expected 1 0", valid, sync_err);
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_strict();
        logic [6:0] f2;
        logic       any_valid_st;
        f2 = 7'b1010101;
        any_valid_st = 1'b0;
        do_reset();
        send_frame(7'b0110010, 1'b0);
        checks++;
        if (valid_st !== 1'b1 || o_st !== 7'b0110010) begin
            failures++;
            $display("FAIL strict_first valid=%b o=%b expected valid=1 o=0110010", valid_st, o_st);
        end
        drive(1'b1, f2[0], 1'b0);
        checks++;
        if (sync_err_st !== 1'b1 || s_st !== 3'd0) begin
            failures++; $display("FAIL strict_err sync_err=%b s=%0d expected 1 0", sync_err_st, s_st);
        end
        checks++;
        if (sync_err !== 1'b0 || s !== 3'd1) begin
            failures++; $display("FAIL lax_slot0 sync_err=%b s=%0d expected 0 1", sync_err, s);
        end
        for (int k = 1; k < 7; k++) begin
            if (k == 6) sb.push_back(f2);
            drive(1'b1, f2[k], 1'b0);
            any_valid_st = any_valid_st | valid_st;
        end
        checks++;
        if (any_valid_st !== 1'b0 || s_st !== 3'd0) begin
            failures++;
            $display("FAIL strict_hunt valid_seen=%b s=%0d expected 0 0", any_valid_st, s_st);
        end
        send_frame(7'b1100110, 1'b0);
        checks++;
        if (valid_st !== 1'b1 || o_st !== 7'b1100110) begin
            failures++;
            $display("FAIL strict_relock valid=%b o=%b expected valid=1 o=1100110", valid_st, o_st);
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 5; k++) drive(1'b1, 1'b1, (k == 0));
        checks++;
        if (s !== 3'd5) begin failures++; $display("FAIL mid_pre_s s=%0d expected=5", s); end
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b1);
        rst_n = 1'b1;
        checks++;
        if (o !== 7'b0 || s !== 3'd0 || valid !== 1'b0 || sync_err !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset o=%b s=%0d valid=%b sync_err=%b expected 0 0 0 0",
                     o, s, valid, sync_err);
        end
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, 1'b0);
        checks++;
        if (s !== 3'd0 || valid !== 1'b0) begin
            failures++; $display("FAIL mid_ignore s=%0d valid=%b expected 0 0", s, valid);
        end
        send_frame(7'b0011010, 1'b0);
        checks++;
        if (o !== 7'b0011010) begin failures++; $display("FAIL mid_next o=%b expected=0011010", o); end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        din   = 1'b0;
        sync  = 1'b0;
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_en_toggle();
        test_sync_err();
        test_strict();
        test_reset_mid();
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (sb.size() != 0) begin
            failures++; $display("FAIL sb_drain pending=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
